// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - Sysbus tag layout, rw/device encodings and responder state enum
package sysbus_pkg;

    localparam int TAG_RW_BIT = 12;
    localparam int TAG_DEV_HI = 11;
    localparam int TAG_DEV_LO = 8;

    localparam logic SYSBUS_READ  = 1'b1;
    localparam logic SYSBUS_WRITE = 1'b0;

    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

    localparam int LINE_BYTES = 64;
    localparam int WORD_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        LAT   = 3'd2,
        RDATA = 3'd3,
        WDATA = 3'd4
    } state_t;

endpackage

// File: rtl/sysbus_mem_array.sv
// rtl/sysbus_mem_array.sv - backing store, async read / sync write, never cleared by reset
module sysbus_mem_array #(
    parameter int WORDS = 1024,
    parameter int DW    = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - Sysbus memory target: one line burst per request, read or write
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 1024,
    parameter int BEATS          = 8,
    parameter int RESP_LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS);
    localparam int LW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

    state_t                    state, state_nx;
    logic [AW-1:0]             base_q;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic [BW:0]               beat_q;
    logic [LW-1:0]             lat_q;

    logic                      req_hit;
    logic                      last_beat;
    logic                      lat_done;
    logic                      mem_we;
    logic [AW-1:0]             mem_addr;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;

    assign req_hit   = bus_reqcyc && (bus_reqtag[TAG_DEV_HI:TAG_DEV_LO] == SYSBUS_MEMORY);
    assign last_beat = (beat_q == (BW+1)'(BEATS - 1));
    assign lat_done  = (lat_q == LW'(RESP_LATENCY - 1));
    // Word index truncates to AW bits, so bursts past the top wrap to word 0.
    assign mem_addr  = base_q + AW'(beat_q[BW-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_hit) state_nx = ACK;
            ACK:     state_nx = (tag_q[TAG_RW_BIT] == SYSBUS_READ) ? LAT : WDATA;
            LAT:     if (lat_done) state_nx = RDATA;
            RDATA:   if (bus_respack && last_beat) state_nx = IDLE;
            WDATA:   if (bus_reqcyc && last_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        mem_we      = 1'b0;
        case (state)
            ACK:   bus_reqack = 1'b1;
            RDATA: begin
                bus_respcyc = 1'b1;
                bus_resp    = mem_rdata;
                bus_resptag = tag_q;
            end
            WDATA: begin
                bus_reqack = bus_reqcyc;
                mem_we     = bus_reqcyc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            tag_q  <= '0;
            beat_q <= '0;
            lat_q  <= '0;
        end else begin
            case (state)
                IDLE: if (req_hit) begin
                    base_q <= bus_req[AW+2:3] & ~AW'(BEATS - 1);
                    tag_q  <= bus_reqtag;
                    beat_q <= '0;
                end
                ACK:   lat_q <= '0;
                LAT:   lat_q <= lat_q + 1'b1;
                RDATA: if (bus_respack) beat_q <= beat_q + 1'b1;
                WDATA: if (bus_reqcyc) beat_q <= beat_q + 1'b1;
                default: ;
            endcase
        end
    end

    sysbus_mem_array #(
        .WORDS (MEM_WORDS),
        .DW    (BUS_DATA_WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus_req),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - scoreboard bench for sysbus_mem_responder
module tb_sysbus_mem_responder;
    import sysbus_pkg::*;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int MW = 1024;
    localparam int NB = 8;
    localparam int RL = 2;

    localparam logic [TW-1:0] RD_TAG = {1'b1, SYSBUS_MEMORY, 8'h05};
    localparam logic [TW-1:0] WR_TAG = {1'b0, SYSBUS_MEMORY, 8'h09};
    localparam logic [TW-1:0] NM_TAG = {1'b1, 4'hE, 8'h01};

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc;
    logic          bus_reqack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_respcyc;
    logic          bus_respack;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ack_cycles  = 0;
    int last_pop_cyc = 0;
    bit toggle_en   = 1'b0;

    logic [TW+DW-1:0] exp_q [$];
    logic [TW+DW-1:0] exp_e;
    logic [DW-1:0]    model [MW];
    logic [DW-1:0]    line_d [NB];

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MW),
        .BEATS          (NB),
        .RESP_LATENCY   (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int word_of(input logic [DW-1:0] addr, input int i);
        int base;
        base = int'((addr >> 3) & 64'h7fff_fff8);
        return (base + i) % MW;
    endfunction

    // Scoreboard monitor: every consumed beat must match the head of the queue.
    always @(negedge clk) begin
        if (bus_reqack) ack_cycles++;
        if (bus_respcyc && bus_respack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("beat_data", bus_resp, exp_e[DW-1:0]);
                check("beat_tag", DW'(bus_resptag), DW'(exp_e[TW+DW-1:DW]));
            end
            last_pop_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 bus_respack = ~bus_respack;
        end
    end

    task automatic send_addr(input logic [DW-1:0] addr, input logic [TW-1:0] tag);
        bit ok;
        ok = 1'b0;
        bus_req    = addr;
        bus_reqtag = tag;
        bus_reqcyc = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (bus_reqack) begin
                ok = 1'b1;
                break;
            end
        end
        check("addr_ack", DW'(ok), 64'd1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_left", DW'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        check("respcyc_after_burst", DW'(bus_respcyc), 64'd0);
    endtask

    task automatic do_write(input logic [DW-1:0] addr);
        send_addr(addr, WR_TAG);
        bus_reqcyc = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NB; i++) begin
            bus_req    = line_d[i];
            bus_reqcyc = 1'b1;
            #1;
            check("wdata_ack", DW'(bus_reqack), 64'd1);
            check("no_resp_in_write", DW'(bus_respcyc), 64'd0);
            model[word_of(addr, i)] = line_d[i];
            @(posedge clk); #1;
        end
        bus_reqcyc = 1'b0;
        #1;
        check("ack_after_write", DW'(bus_reqack), 64'd0);
    endtask

    task automatic do_read(input logic [DW-1:0] addr);
        int t0;
        for (int i = 0; i < NB; i++) exp_q.push_back({RD_TAG, model[word_of(addr, i)]});
        send_addr(addr, RD_TAG);
        bus_reqcyc = 1'b0;
        t0 = cyc;
        for (int n = 0; n < 50; n++) begin
            if (bus_respcyc) break;
            @(posedge clk); #1;
        end
        check("first_beat_latency", DW'(cyc - t0), DW'(RL + 1));
        wait_drain();
    endtask

    initial begin
        int ack2_cyc;
        reset       = 1'b1;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        for (int i = 0; i < MW; i++) model[i] = 'x;
        repeat (3) @(posedge clk);
        #1;
        check("rst_reqack", DW'(bus_reqack), 64'd0);
        check("rst_respcyc", DW'(bus_respcyc), 64'd0);
        check("rst_resp", bus_resp, 64'd0);
        check("rst_resptag", DW'(bus_resptag), 64'd0);
        reset = 1'b0;

        // Preload lines at words 0x40 and 0x08 through the write path.
        for (int i = 0; i < NB; i++) line_d[i] = 64'h1111 * i;
        do_write(64'h200);
        for (int i = 0; i < NB; i++) line_d[i] = 64'h5000 + i;
        do_write(64'h40);

        // 1) read with respack held high: one ack pulse, beats 0x0..0x7777
        bus_respack = 1'b1;
        ack_cycles  = 0;
        do_read(64'h200);
        check("read_ack_pulses", DW'(ack_cycles), 64'd1);

        // 2) respack toggling
        toggle_en = 1'b1;
        do_read(64'h200);
        toggle_en = 1'b0;
        #2;
        bus_respack = 1'b1;

        // 3) write then read back
        for (int i = 0; i < NB; i++) line_d[i] = 64'hA0 + i;
        do_write(64'h1C0);
        do_read(64'h1C0);

        // 4) foreign device tag is never acknowledged; address wrap
        ack_cycles = 0;
        bus_req    = 64'h200;
        bus_reqtag = NM_TAG;
        bus_reqcyc = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("nonmem_no_ack", DW'(ack_cycles), 64'd0);
        bus_reqcyc = 1'b0;
        @(posedge clk); #1;
        do_read(64'(MW * 8 + 'h40));

        // 5) reset during beat 3, then a clean read
        bus_respack = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back({RD_TAG, 64'h1111 * i});
        send_addr(64'h200, RD_TAG);
        bus_reqcyc = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (bus_respcyc) break;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            bus_respack = 1'b1;
            @(posedge clk); #1;
            bus_respack = 1'b0;
        end
        #1;
        check("beat3_before_reset", bus_resp, 64'h3333);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_respcyc", DW'(bus_respcyc), 64'd0);
        check("reset_reqack", DW'(bus_reqack), 64'd0);
        check("reset_partial_pops", DW'(exp_q.size()), 64'd0);
        reset = 1'b0;
        bus_respack = 1'b1;
        do_read(64'h200);

        // back-to-back reads with reqcyc held
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NB; i++) exp_q.push_back({RD_TAG, model[word_of(64'h200, i)]});
        send_addr(64'h200, RD_TAG);
        ack2_cyc = -1;
        @(posedge clk); #1;
        for (int n = 0; n < 100; n++) begin
            if (bus_reqack) begin
                ack2_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        bus_reqcyc = 1'b0;
        check("b2b_second_ack_gap", DW'(ack2_cyc - last_pop_cyc), 64'd2);
        check("b2b_first_burst_done", DW'(exp_q.size()), DW'(NB));
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
